call_return_ctrl: RTL and testbench
===================================

// Module: call_return_ctrl
// PURPOSE
//  Front-end sequencer for the return-address stack. Decodes CALL/RET from the
//  decode stage, drives the one-cycle push/pop strobes and push data, captures
//  popped data and issues a PC redirect to fetch.
//  Tracks stack occupancy and traps overflow/underflow so the stack is never
//  written past full or read past empty. Sits between decode and the stack block.
// PARAMETERS
//  AW     19   address / PC width, matches stack data width
//  DEPTH  256  stack entries (1024-word store, 4-word stride)
//  CW     9    width of depth counter, = $clog2(DEPTH+1)
// PORTS
//  clk            in   1    system clock, rising edge
//  rst            in   1    synchronous reset, active-high
//  instr_valid    in   1    decode presents an instruction this cycle
//  is_call        in   1    instruction is CALL (qualified by instr_valid)
//  is_ret         in   1    instruction is RET  (qualified by instr_valid)
//  ret_addr       in   AW   return address for CALL (PC of next instr)
//  call_target    in   AW   CALL destination
//  err_clr        in   1    clears sticky overflow/underflow/illegal flags
//  ready          out  1    1 = IDLE, can accept CALL/RET this cycle
//  push           out  1    stack push strobe, 1 cycle
//  pop            out  1    stack pop strobe, 1 cycle
//  push_data      out  AW   data written by push
//  stk_data       in   AW   stack pop data, valid the cycle after pop
//  redir_valid    out  1    PC redirect strobe, 1 cycle
//  redir_pc       out  AW   redirect target
//  depth          out  CW   current stack occupancy
//  overflow       out  1    sticky: CALL attempted at depth==DEPTH
//  underflow      out  1    sticky: RET attempted at depth==0
//  illegal        out  1    sticky: is_call & is_ret both set
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, ready=1, push=pop=0,
//    push_data=0, redir_valid=0, redir_pc=0, depth=0, all sticky flags=0.
//  - States: IDLE, PUSH, POP, WAIT, REDIR.
//  - Accept only when instr_valid & ready; instr_valid while ready=0 ignored
//    (decode must hold the instruction until ready=1).
//  - CALL (depth<DEPTH): IDLE->PUSH; push=1, push_data=ret_addr;
//    depth+1 in the same cycle; PUSH->REDIR with redir_pc=call_target;
//    REDIR->IDLE. push is high 1 cycle after accept, redir_valid 2 cycles after.
//  - RET (depth>0): IDLE->POP; pop=1, depth-1; POP->WAIT (stack updates);
//    WAIT samples stk_data into redir_pc; WAIT->REDIR (redir_valid=1);
//    REDIR->IDLE. redir_valid 3 cycles after accept.
//  - CALL at depth==DEPTH: overflow<=1, no push, no redirect, stay IDLE.
//  - RET at depth==0: underflow<=1, no pop, no redirect, stay IDLE.
//  - is_call & is_ret together: illegal<=1, no action, stay IDLE.
//  - Sticky flags hold until rst or err_clr; err_clr in the same cycle as a
//    new error: the set wins.
//  - depth never wraps; saturation is guaranteed by the overflow/underflow checks.
//  - ready=0 in PUSH, POP, WAIT and REDIR; ready=1 again the cycle after REDIR.
//  - rst mid-operation: next edge forces IDLE and clears strobes and depth;
//    any pending redirect is dropped. The stack is reset in the same cycle.
//  - push and pop are never high together; no back-to-back strobes.
// TESTING
//  1 rst; CALL ret_addr=0x00104, target=0x02000 -> push=1 at +1 with
//    push_data=0x00104, redir_valid=1 at +2 with redir_pc=0x02000, depth=1.
//  2 After test 1, RET; stack returns 0x00104 -> pop=1 at +1,
//    redir_valid at +3 with redir_pc=0x00104, depth=0.
//  3 RET at depth=0 -> underflow=1, no pop, no redir_valid; err_clr -> 0.
//  4 256 CALLs then a 257th -> depth=256, overflow=1, 257th gives no push;
//    then 256 RETs return addresses in LIFO order.
//  5 is_call=is_ret=1 -> illegal=1, no strobes; instr_valid while
//    ready=0 -> ignored, depth unchanged.
//  6 rst asserted in WAIT -> next cycle IDLE, redir_valid never asserted,
//    depth=0, ready=1.

Source files
------------

// File: rtl/call_return_ctrl_if.sv
// Bus between decode/stack (master side) and the call/return sequencer (slave side).
interface call_return_ctrl_if #(
  parameter int AW = 19,
  parameter int CW = 9
);
  logic          instr_valid;
  logic          is_call;
  logic          is_ret;
  logic [AW-1:0] ret_addr;
  logic [AW-1:0] call_target;
  logic          err_clr;
  logic          ready;
  logic          push;
  logic          pop;
  logic [AW-1:0] push_data;
  logic [AW-1:0] stk_data;
  logic          redir_valid;
  logic [AW-1:0] redir_pc;
  logic [CW-1:0] depth;
  logic          overflow;
  logic          underflow;
  logic          illegal;

  modport master (
    output instr_valid, is_call, is_ret, ret_addr, call_target, err_clr, stk_data,
    input  ready, push, pop, push_data, redir_valid, redir_pc, depth,
           overflow, underflow, illegal
  );

  modport slave (
    input  instr_valid, is_call, is_ret, ret_addr, call_target, err_clr, stk_data,
    output ready, push, pop, push_data, redir_valid, redir_pc, depth,
           overflow, underflow, illegal
  );
endinterface

// File: rtl/call_return_ctrl.sv
// Sequences CALL/RET into return-address-stack push/pop strobes and a PC redirect,
// tracking occupancy and trapping overflow, underflow and illegal encodings.
module call_return_ctrl #(
  parameter int AW    = 19,
  parameter int DEPTH = 256,
  parameter int CW    = 9
) (
  input logic              clk,
  input logic              rst,
  call_return_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PUSH, POP, WAIT, REDIR} state_t;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t        state;
  logic [AW-1:0] target;

  logic accept, both, do_call, do_ret, full, empty;

  assign accept  = bus.instr_valid & bus.ready;
  assign both    = bus.is_call & bus.is_ret;
  assign do_call = accept & bus.is_call & ~bus.is_ret;
  assign do_ret  = accept & bus.is_ret & ~bus.is_call;
  assign full    = (bus.depth == FULL);
  assign empty   = (bus.depth == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      target          <= '0;
      bus.ready       <= 1'b1;
      bus.push        <= 1'b0;
      bus.pop         <= 1'b0;
      bus.push_data   <= '0;
      bus.redir_valid <= 1'b0;
      bus.redir_pc    <= '0;
      bus.depth       <= '0;
      bus.overflow    <= 1'b0;
      bus.underflow   <= 1'b0;
      bus.illegal     <= 1'b0;
    end else begin
      bus.push        <= 1'b0;
      bus.pop         <= 1'b0;
      bus.redir_valid <= 1'b0;

      // Clear first so a simultaneous new error still sets its flag.
      if (bus.err_clr) begin
        bus.overflow  <= 1'b0;
        bus.underflow <= 1'b0;
        bus.illegal   <= 1'b0;
      end
      if (accept & both)    bus.illegal   <= 1'b1;
      if (do_call & full)   bus.overflow  <= 1'b1;
      if (do_ret  & empty)  bus.underflow <= 1'b1;

      case (state)
        IDLE: begin
          if (do_call && !full) begin
            bus.push      <= 1'b1;
            bus.push_data <= bus.ret_addr;
            target        <= bus.call_target;
            bus.depth     <= bus.depth + CW'(1);
            bus.ready     <= 1'b0;
            state         <= PUSH;
          end else if (do_ret && !empty) begin
            bus.pop   <= 1'b1;
            bus.depth <= bus.depth - CW'(1);
            bus.ready <= 1'b0;
            state     <= POP;
          end
        end
        PUSH: begin
          bus.redir_valid <= 1'b1;
          bus.redir_pc    <= target;
          state           <= REDIR;
        end
        POP:  state <= WAIT;
        WAIT: begin
          // Stack read data is valid only now, one cycle after the pop strobe.
          bus.redir_pc    <= bus.stk_data;
          bus.redir_valid <= 1'b1;
          state           <= REDIR;
        end
        REDIR: begin
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed bench for call_return_ctrl with a behavioural return-address stack.
module tb_call_return_ctrl;

  localparam int AW = 19;
  localparam int CW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  call_return_ctrl_if #(.AW(AW), .CW(CW)) bus ();

  call_return_ctrl #(.AW(AW), .DEPTH(256), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stack model: push writes on the strobe edge, pop data appears the cycle after.
  logic [AW-1:0] mem [0:255];
  int            sp;

  always @(posedge clk) begin
    if (rst) begin
      sp           <= 0;
      bus.stk_data <= '0;
    end else if (bus.push) begin
      mem[sp[7:0]] <= bus.push_data;
      sp           <= sp + 1;
    end else if (bus.pop) begin
      bus.stk_data <= mem[(sp - 1) & 255];
      sp           <= sp - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) check("push_pop_excl", 32'(bus.push & bus.pop), 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready, presents one instruction for one edge, then clears.
  task automatic issue(input logic c, input logic r, input logic [AW-1:0] ra,
                       input logic [AW-1:0] tgt);
    for (int k = 0; k < 8 && !bus.ready; k++) step();
    if (!bus.ready) check("ready_wait", 32'(bus.ready), 32'd1);
    bus.instr_valid = 1'b1;
    bus.is_call     = c;
    bus.is_ret      = r;
    bus.ret_addr    = ra;
    bus.call_target = tgt;
    step();
    bus.instr_valid = 1'b0;
    bus.is_call     = 1'b0;
    bus.is_ret      = 1'b0;
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.is_call     = 1'b0;
    bus.is_ret      = 1'b0;
    bus.ret_addr    = '0;
    bus.call_target = '0;
    bus.err_clr     = 1'b0;

    // Reset values
    step(); step();
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_push", 32'(bus.push), 32'd0);
    check("rst_pop", 32'(bus.pop), 32'd0);
    check("rst_depth", 32'(bus.depth), 32'd0);
    check("rst_redir_pc", 32'(bus.redir_pc), 32'd0);
    check("rst_flags", {29'd0, bus.overflow, bus.underflow, bus.illegal}, 32'd0);
    rst = 1'b0;
    step();

    // 1: CALL
    issue(1'b1, 1'b0, 19'h00104, 19'h02000);
    check("t1_push", 32'(bus.push), 32'd1);
    check("t1_push_data", 32'(bus.push_data), 32'h00104);
    check("t1_depth", 32'(bus.depth), 32'd1);
    check("t1_ready_lo", 32'(bus.ready), 32'd0);
    check("t1_redir_early", 32'(bus.redir_valid), 32'd0);
    step();
    check("t1_redir_valid", 32'(bus.redir_valid), 32'd1);
    check("t1_redir_pc", 32'(bus.redir_pc), 32'h02000);
    check("t1_push_1cyc", 32'(bus.push), 32'd0);
    step();
    check("t1_redir_1cyc", 32'(bus.redir_valid), 32'd0);
    check("t1_ready_back", 32'(bus.ready), 32'd1);

    // 2: RET
    issue(1'b0, 1'b1, '0, '0);
    check("t2_pop", 32'(bus.pop), 32'd1);
    check("t2_depth", 32'(bus.depth), 32'd0);
    step();
    check("t2_pop_1cyc", 32'(bus.pop), 32'd0);
    check("t2_redir_p2", 32'(bus.redir_valid), 32'd0);
    step();
    check("t2_redir_valid", 32'(bus.redir_valid), 32'd1);
    check("t2_redir_pc", 32'(bus.redir_pc), 32'h00104);
    step();
    check("t2_ready_back", 32'(bus.ready), 32'd1);

    // 3: underflow, set-wins against err_clr, then clear
    issue(1'b0, 1'b1, '0, '0);
    check("t3_underflow", 32'(bus.underflow), 32'd1);
    check("t3_no_pop", 32'(bus.pop), 32'd0);
    check("t3_ready", 32'(bus.ready), 32'd1);
    step();
    check("t3_no_redir", 32'(bus.redir_valid), 32'd0);
    bus.err_clr = 1'b1;
    issue(1'b0, 1'b1, '0, '0);
    bus.err_clr = 1'b0;
    check("t3_set_wins", 32'(bus.underflow), 32'd1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("t3_cleared", 32'(bus.underflow), 32'd0);

    // 4: fill, overflow, LIFO drain
    for (int i = 0; i < 256; i++) issue(1'b1, 1'b0, AW'(32'h10000 + i * 4), AW'(32'h30000 + i));
    step(); step();
    check("t4_depth_full", 32'(bus.depth), 32'd256);
    check("t4_no_ovf_yet", 32'(bus.overflow), 32'd0);
    issue(1'b1, 1'b0, 19'h7ffff, 19'h7ffff);
    check("t4_overflow", 32'(bus.overflow), 32'd1);
    check("t4_no_push", 32'(bus.push), 32'd0);
    check("t4_depth_hold", 32'(bus.depth), 32'd256);
    step();
    check("t4_no_redir", 32'(bus.redir_valid), 32'd0);
    for (int i = 255; i >= 0; i--) begin
      issue(1'b0, 1'b1, '0, '0);
      step(); step();
      check("t4_lifo_valid", 32'(bus.redir_valid), 32'd1);
      check("t4_lifo_pc", 32'(bus.redir_pc), 32'h10000 + i * 4);
    end
    step();
    check("t4_depth_empty", 32'(bus.depth), 32'd0);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("t4_ovf_cleared", 32'(bus.overflow), 32'd0);

    // 5: illegal encoding; instruction while busy is ignored
    issue(1'b1, 1'b1, 19'h00200, 19'h00300);
    check("t5_illegal", 32'(bus.illegal), 32'd1);
    check("t5_no_strobe", {30'd0, bus.push, bus.pop}, 32'd0);
    check("t5_depth", 32'(bus.depth), 32'd0);
    step();
    check("t5_no_redir", 32'(bus.redir_valid), 32'd0);
    issue(1'b1, 1'b0, 19'h00400, 19'h00500);
    bus.instr_valid = 1'b1;
    bus.is_ret      = 1'b1;
    step();
    check("t5_busy_pop", 32'(bus.pop), 32'd0);
    step();
    bus.instr_valid = 1'b0;
    bus.is_ret      = 1'b0;
    check("t5_busy_pop2", 32'(bus.pop), 32'd0);
    step();
    check("t5_depth_kept", 32'(bus.depth), 32'd1);
    check("t5_ready", 32'(bus.ready), 32'd1);

    // 6: reset while waiting for stack data
    issue(1'b1, 1'b0, 19'h00600, 19'h00700);
    issue(1'b0, 1'b1, '0, '0);
    check("t6_pop", 32'(bus.pop), 32'd1);
    check("t6_depth_pre", 32'(bus.depth), 32'd1);
    step();
    rst = 1'b1;
    step();
    check("t6_ready", 32'(bus.ready), 32'd1);
    check("t6_depth", 32'(bus.depth), 32'd0);
    check("t6_redir", 32'(bus.redir_valid), 32'd0);
    check("t6_illegal_clr", 32'(bus.illegal), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t6_no_redir", 32'(bus.redir_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
